mchan_push_arbiter: RTL
=======================

# mchan_push_arbiter

Round-robin arbiter that shares the single push port of one mchan FIFO between `NB_REQ` requesters. Requesters send bursts of beats, delimited by `last_i`. Once a burst's first beat is accepted, the winner keeps the port until its last beat or a forced release after `MAX_BURST` beats, so beats from different requesters never interleave inside a burst. It sits between the mchan command/transfer sources and the FIFO push side (`push_req`/`push_gnt`/`push_dat`).

## Interface
- `NB_REQ`, default 4: number of requesters, legal range 2..16.
- `DATA_WIDTH`, default 32: beat width in bits.
- `MAX_BURST`, default 8: maximum beats per grant before forced release, legal range ≥ 1.
- `ID_WIDTH`, derived as `$clog2(NB_REQ)`: width of the source id.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_i`  in  NB_REQ  per-requester beat valid.
- `dat_i`  in  NB_REQ*DATA_WIDTH  per-requester beat data; requester k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `last_i`  in  NB_REQ  per-requester flag marking the final beat of a burst.
- `gnt_o`  out  NB_REQ  one-hot; beat of requester k accepted this cycle.
- `push_req_o`  out  1  to FIFO `push_req`.
- `push_dat_o`  out  DATA_WIDTH  to FIFO `push_dat`.
- `push_id_o`  out  ID_WIDTH  index of the requester driving `push_dat_o`.
- `push_gnt_i`  in  1  from FIFO `push_gnt` (low when full).
- `busy_o`  out  1  high while in state LOCKED.
- `owner_o`  out  ID_WIDTH  current owner; holds the last owner when idle.

## Operation
States:
- **IDLE**: no burst in progress.
- **LOCKED**: owner register `owner_q` holds the port.

Registers:
- `state`
- `rr_ptr` (ID_WIDTH bits)
- `owner_q`
- `beat_cnt` (`$clog2(MAX_BURST+1)` bits)

Selection:
- In IDLE, the candidate is the first k with `req_i[k]=1`, searching from `rr_ptr` upward and wrapping at `NB_REQ-1` to 0.
- In LOCKED, the candidate is `owner_q`.

Datapath:
- `push_req_o = req_i[cand]`; it is 0 in IDLE when no `req_i` bit is set.
- `push_dat_o` and `push_id_o` are driven from the candidate. Their value is don't-care when `push_req_o=0`.
- Transfer (xfer) = `push_req_o & push_gnt_i`.
- `gnt_o[cand]` = xfer; all other `gnt_o` bits are 0.

Transitions (evaluated on xfer only; without xfer, all registers hold):
- IDLE, `last_i[cand]=1` or `MAX_BURST=1`: stay IDLE, `rr_ptr <= cand+1` (wrapping).
- IDLE, otherwise: go to LOCKED, `owner_q <= cand`, `beat_cnt <= 1`.
- LOCKED, `last_i[owner_q]=1` or `beat_cnt+1 == MAX_BURST`: go to IDLE, `rr_ptr <= owner_q+1` (wrapping), `beat_cnt <= 0`.
- LOCKED, otherwise: `beat_cnt <= beat_cnt+1`.

Boundary behaviour:
- Owner deasserts `req_i` mid-burst: stay LOCKED with `push_req_o=0`. Other requesters are not served.
- FIFO full (`push_gnt_i=0`): no grant, and `rr_ptr`, state and counter are unchanged. The candidate may change next cycle only in IDLE.
- Forced release: the next beat of the same burst re-arbitrates as a new burst.
- `rr_ptr` wrap: after the owner at `NB_REQ-1` is released, `rr_ptr=0`.
- Reset: `rst_i=1` at any time, including mid-burst, forces IDLE, `rr_ptr=0`, `owner_q=0`, `beat_cnt=0` at the next edge. In-flight burst state is discarded.

## Timing
- Arbitration and grant are combinational in the same cycle: a `req_i` presented with `push_gnt_i=1` is accepted in that cycle.
- The state update is visible in the next cycle.
- No registered output stage. The outputs depend combinationally on `req_i`, `dat_i` and `push_gnt_i`. The integrator must not create a loop through the FIFO grant.
- A requester holds `req_i`, `dat_i` and `last_i` stable until it sees `gnt_o[k]=1`.
- Values held while `rst_i` is asserted and after reset, until the first request:
  - `busy_o=0`, `owner_o=0`
  - `gnt_o=0`, `push_req_o=0`
  - `push_id_o=0`, `push_dat_o=0`, since `rr_ptr=0` selects requester 0, which idles at zero.
- Throughput: one beat per cycle while the FIFO grants. There are no bubbles between back-to-back bursts from different requesters, because IDLE arbitrates in the same cycle the previous burst releases.

## Test plan
- **Fairness**: reset, then requesters 0..3 all post single-beat bursts (`last_i=1`) continuously with `push_gnt_i=1` → gnt order 0,1,2,3,0,1 with one grant per cycle, and `push_id_o` matches.
- **Burst lock**: requester 1 posts 3 beats (last on beat 3) while requester 0 requests continuously → gnt 1,1,1 then 0. `busy_o=1` on cycles 2–3, `owner_o=1`.
- **Forced release**: with `MAX_BURST=4`, requester 2 posts 6 beats without last and requester 3 is requesting → 2,2,2,2,3, then 2 resumes afterwards.
- **FIFO full**: mid-burst, `push_gnt_i=0` for 5 cycles → `gnt_o=0`, `beat_cnt` and `owner_o` frozen; resumes with the correct beat count.
- **Owner stall**: the owner drops `req_i` for 2 cycles mid-burst while others request → `push_req_o=0`, no other grants, and the lock is kept.
- **Reset mid-burst**: `rst_i=1` while LOCKED at beat 2 → next cycle `busy_o=0`, `rr_ptr=0`, and requester 0 wins first after reset if it is requesting.

Source files
------------

// File: rtl/mchan_push_arbiter.sv
// Round-robin arbiter sharing one mchan FIFO push port between NB_REQ burst sources.
// Zero-latency combinational grant; a burst owner keeps the port until last_i or MAX_BURST beats, and push_gnt_i=0 freezes everything.
module mchan_push_arbiter #(
  parameter int unsigned NB_REQ     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned ID_WIDTH   = $clog2(NB_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NB_REQ-1:0]            req_i,
  input  logic [NB_REQ*DATA_WIDTH-1:0] dat_i,
  input  logic [NB_REQ-1:0]            last_i,
  output logic [NB_REQ-1:0]            gnt_o,
  output logic                         push_req_o,
  output logic [DATA_WIDTH-1:0]        push_dat_o,
  output logic [ID_WIDTH-1:0]          push_id_o,
  input  logic                         push_gnt_i,
  output logic                         busy_o,
  output logic [ID_WIDTH-1:0]          owner_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [ID_WIDTH-1:0] rr_cand, cand;
  logic                xfer, cand_last;

  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] id);
    if (32'(id) == NB_REQ - 1) return '0;
    return id + 1'b1;
  endfunction

  // Walk offsets from the far end so the requester closest to rr_ptr is the last one written.
  always_comb begin
    rr_cand = rr_ptr_q;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + 32'(i)) % NB_REQ;
      if (req_i[idx]) rr_cand = ID_WIDTH'(idx);
    end
  end

  assign cand       = (state_q == LOCKED) ? owner_q : rr_cand;
  assign push_req_o = req_i[cand];
  assign push_dat_o = dat_i[cand*DATA_WIDTH +: DATA_WIDTH];
  assign push_id_o  = cand;
  assign cand_last  = last_i[cand];
  assign xfer       = push_req_o & push_gnt_i;
  assign busy_o     = (state_q == LOCKED);
  assign owner_o    = owner_q;

  always_comb begin
    gnt_o       = '0;
    gnt_o[cand] = xfer;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    if (xfer) begin
      unique case (state_q)
        IDLE: begin
          if (cand_last || MAX_BURST == 1) begin
            rr_ptr_d = wrap_inc(cand);
          end else begin
            state_d    = LOCKED;
            owner_d    = cand;
            beat_cnt_d = CNT_W'(1);
          end
        end
        LOCKED: begin
          if (cand_last || (beat_cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST)) begin
            state_d    = IDLE;
            rr_ptr_d   = wrap_inc(owner_q);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
